// File: rtl/fifo_flush_pkg.sv
// Shared types and helpers for the width-converting flush FIFO.
package fifo_flush_pkg;

    typedef enum logic [1:0] {IDLE, PAD, DRAIN, DONE} flush_state_t;

    localparam int unsigned FLUSH_DRAIN   = 0;
    localparam int unsigned FLUSH_DISCARD = 1;

    // Widest output word the pad-merge helper can handle.
    localparam int unsigned MERGE_MAX_W = 1024;

    // Keep the low keep_bits of held and take every higher bit from pad.
    function automatic logic [MERGE_MAX_W-1:0] pad_merge(
        input logic [MERGE_MAX_W-1:0] held,
        input logic [MERGE_MAX_W-1:0] pad,
        input int unsigned            keep_bits
    );
        logic [MERGE_MAX_W-1:0] keep_mask;
        keep_mask = ~({MERGE_MAX_W{1'b1}} << keep_bits);
        return (held & keep_mask) | (pad & ~keep_mask);
    endfunction

endpackage

// File: rtl/fifo_packer.sv
// Lane packer: gathers IN_W-bit lanes LSB-first into OUT_W-bit words.
module fifo_packer
    import fifo_flush_pkg::*;
#(
    parameter int unsigned      IN_W    = 4,
    parameter int unsigned      RATIO   = 8,
    parameter logic [IN_W-1:0]  PAD_VAL = '0,
    localparam int unsigned     OUT_W   = IN_W * RATIO,
    localparam int unsigned     PW      = $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_data,
    input  logic             pad_en,
    output logic [PW-1:0]    partial,
    output logic             push,
    output logic [OUT_W-1:0] push_word
);

    logic [RATIO-1:0][IN_W-1:0] lanes;
    logic [RATIO-1:0][IN_W-1:0] full_lanes;
    logic                       last_lane;

    assign last_lane = wr_en && (partial == PW'(RATIO - 1));

    // The closing lane is pushed on the same edge, so splice it in directly.
    always_comb begin
        full_lanes            = lanes;
        full_lanes[RATIO - 1] = wr_data;
    end

    assign push      = last_lane || pad_en;
    assign push_word = pad_en
        ? OUT_W'(pad_merge(MERGE_MAX_W'(lanes), MERGE_MAX_W'({RATIO{PAD_VAL}}),
                           32'(partial) * IN_W))
        : full_lanes;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes   <= '0;
            partial <= '0;
        end else if (pad_en) begin
            partial <= '0;
        end else if (wr_en) begin
            lanes[partial] <= wr_data;
            partial        <= last_lane ? '0 : partial + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_flush_pack.sv
// Width-converting FIFO with flush: packer front end, word storage and flush FSM.
module fifo_flush_pack
    import fifo_flush_pkg::*;
#(
    parameter int unsigned     IN_W       = 4,
    parameter int unsigned     RATIO      = 8,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [IN_W-1:0] PAD_VAL    = '0,
    parameter int unsigned     FLUSH_MODE = FLUSH_DRAIN,
    localparam int unsigned    OUT_W      = IN_W * RATIO,
    localparam int unsigned    LW         = $clog2(DEPTH + 1),
    localparam int unsigned    PW         = $clog2(RATIO),
    localparam int unsigned    AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_wr_valid_i,
    input  logic [IN_W-1:0]  fifo_wr_data_i,
    output logic             fifo_wr_ready_o,
    input  logic             fifo_rd_valid_i,
    output logic [OUT_W-1:0] fifo_rd_data_o,
    output logic             fifo_data_avail_o,
    input  logic             fifo_flush_i,
    output logic             fifo_flush_done_o,
    output logic             fifo_empty_o,
    output logic             fifo_full_o,
    output logic [LW-1:0]    fifo_level_o,
    output logic [PW-1:0]    fifo_partial_o
);

    flush_state_t     state, state_nxt;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [PW-1:0]    partial;
    logic [OUT_W-1:0] push_word;
    logic             wr_en, pad_en, pop, push, discard;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full_o       = (level == LW'(DEPTH));
    assign fifo_data_avail_o = (level != '0);
    assign fifo_empty_o      = !fifo_data_avail_o && (partial == '0);
    assign fifo_level_o      = level;
    assign fifo_partial_o    = partial;
    assign fifo_flush_done_o = (state == DONE);
    assign fifo_rd_data_o    = fifo_data_avail_o ? mem[rd_ptr] : '0;
    assign fifo_wr_ready_o   = (state == IDLE) && !fifo_flush_i
                               && !(fifo_full_o && (partial == PW'(RATIO - 1)));

    assign wr_en   = fifo_wr_valid_i && fifo_wr_ready_o;
    assign pop     = fifo_rd_valid_i && fifo_data_avail_o;
    // A pop on the same edge frees the slot the pad word lands in.
    assign pad_en  = (state == PAD) && (!fifo_full_o || pop);
    assign discard = (state == DRAIN) && (FLUSH_MODE == FLUSH_DISCARD);

    fifo_packer #(
        .IN_W    (IN_W),
        .RATIO   (RATIO),
        .PAD_VAL (PAD_VAL)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (fifo_wr_data_i),
        .pad_en    (pad_en),
        .partial   (partial),
        .push      (push),
        .push_word (push_word)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (discard) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_flush_i) state_nxt = (partial != '0) ? PAD : DRAIN;
            PAD:     if (pad_en) state_nxt = DRAIN;
            DRAIN:   if (discard || level == '0) state_nxt = DONE;
            DONE:    if (!fifo_flush_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_flush_pack.sv
// Bench for fifo_flush_pack: drain and discard instances share stimulus and are checked against a queue model.
module tb_fifo_flush_pack;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned RATIO = 8;
    localparam int unsigned DEPTH = 4;

    localparam int P_IDLE  = 0;
    localparam int P_PAD   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_data = 4'h0;
    logic        rd_valid = 1'b0;
    logic        flush = 1'b0;

    logic        wr_ready   [2];
    logic [31:0] rd_data    [2];
    logic        data_avail [2];
    logic        flush_done [2];
    logic        empty      [2];
    logic        full       [2];
    logic [2:0]  level      [2];
    logic [2:0]  partial    [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Behavioural model: stored words as a queue, held lanes as an array.
    logic [31:0] mq [2][$];
    logic [3:0]  ml [2][RATIO];
    int          np [2];
    int          ph [2];

    always #5 clk = ~clk;

    fifo_flush_pack #(
        .IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .PAD_VAL(4'h0), .FLUSH_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .fifo_wr_valid_i(wr_valid), .fifo_wr_data_i(wr_data), .fifo_wr_ready_o(wr_ready[0]),
        .fifo_rd_valid_i(rd_valid), .fifo_rd_data_o(rd_data[0]), .fifo_data_avail_o(data_avail[0]),
        .fifo_flush_i(flush), .fifo_flush_done_o(flush_done[0]), .fifo_empty_o(empty[0]),
        .fifo_full_o(full[0]), .fifo_level_o(level[0]), .fifo_partial_o(partial[0])
    );

    fifo_flush_pack #(
        .IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .PAD_VAL(4'h0), .FLUSH_MODE(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .fifo_wr_valid_i(wr_valid), .fifo_wr_data_i(wr_data), .fifo_wr_ready_o(wr_ready[1]),
        .fifo_rd_valid_i(rd_valid), .fifo_rd_data_o(rd_data[1]), .fifo_data_avail_o(data_avail[1]),
        .fifo_flush_i(flush), .fifo_flush_done_o(flush_done[1]), .fifo_empty_o(empty[1]),
        .fifo_full_o(full[1]), .fifo_level_o(level[1]), .fifo_partial_o(partial[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int m, input int held);
        logic [31:0] w = '0;
        for (int i = 0; i < int'(RATIO); i++)
            if (i < held) w = w | (32'(ml[m][i]) << (i * int'(IN_W)));
        return w;
    endfunction

    function automatic bit model_ready(input int m);
        return ph[m] == P_IDLE && !flush
               && !(mq[m].size() == int'(DEPTH) && np[m] == int'(RATIO) - 1);
    endfunction

    task automatic model_reset(input int m);
        mq[m].delete();
        np[m] = 0;
        ph[m] = P_IDLE;
    endtask

    task automatic model_step(input int m);
        bit          pop, do_push, cleared;
        logic [31:0] w;
        pop     = rd_valid && mq[m].size() > 0;
        do_push = 1'b0;
        cleared = 1'b0;
        w       = '0;
        case (ph[m])
            P_IDLE: begin
                if (flush) ph[m] = (np[m] != 0) ? P_PAD : P_DRAIN;
                else if (wr_valid && model_ready(m)) begin
                    ml[m][np[m]] = wr_data;
                    np[m]++;
                    if (np[m] == int'(RATIO)) begin
                        w = model_word(m, int'(RATIO));
                        do_push = 1'b1;
                        np[m] = 0;
                    end
                end
            end
            P_PAD: begin
                if (mq[m].size() < int'(DEPTH) || pop) begin
                    w = model_word(m, np[m]);
                    do_push = 1'b1;
                    np[m] = 0;
                    ph[m] = P_DRAIN;
                end
            end
            P_DRAIN: begin
                if (m == 1) begin
                    mq[m].delete();
                    cleared = 1'b1;
                    ph[m] = P_DONE;
                end else if (mq[m].size() == 0) ph[m] = P_DONE;
            end
            default: if (!flush) ph[m] = P_IDLE;
        endcase
        if (pop && !cleared) void'(mq[m].pop_front());
        if (do_push) mq[m].push_back(w);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) for (int m = 0; m < 2; m++) model_reset(m);
        else        for (int m = 0; m < 2; m++) model_step(m);
    end

    always @(negedge clk) begin
        if (reset && chk_on) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d_level", m), 32'(level[m]), 32'(mq[m].size()));
                chk($sformatf("m%0d_rd_data", m), rd_data[m], mq[m].size() > 0 ? mq[m][0] : 32'h0);
                chk($sformatf("m%0d_avail", m), 32'(data_avail[m]), 32'(mq[m].size() != 0));
                chk($sformatf("m%0d_full", m), 32'(full[m]), 32'(mq[m].size() == int'(DEPTH)));
                chk($sformatf("m%0d_partial", m), 32'(partial[m]), 32'(np[m]));
                chk($sformatf("m%0d_empty", m), 32'(empty[m]), 32'(mq[m].size() == 0 && np[m] == 0));
                chk($sformatf("m%0d_done", m), 32'(flush_done[m]), 32'(ph[m] == P_DONE));
                chk($sformatf("m%0d_wr_ready", m), 32'(wr_ready[m]), 32'(model_ready(m)));
            end
        end
    end

    task automatic cyc(input logic wv, input logic [3:0] wd, input logic rv, input logic fl);
        #1;
        wr_valid = wv;
        wr_data  = wd;
        rd_valid = rv;
        flush    = fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          fl_hold;
        logic        wv, rv, fl;
        logic [3:0]  wd;
        fl_hold = 0;
        @(negedge clk);
        do_reset();
        chk_on = 1'b1;

        // Reset state and one full word
        for (int m = 0; m < 2; m++) begin
            chk("rst_level", 32'(level[m]), 32'd0);
            chk("rst_empty", 32'(empty[m]), 32'd1);
            chk("rst_rd_data", rd_data[m], 32'h0);
            chk("rst_wr_ready", 32'(wr_ready[m]), 32'd1);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 1), 1'b0, 1'b0);
        chk("t1_avail", 32'(data_avail[0]), 32'd1);
        chk("t1_level", 32'(level[0]), 32'd1);
        chk("t1_word", rd_data[0], 32'h87654321);
        chk("t1_partial", 32'(partial[0]), 32'd0);
        chk("t1_empty", 32'(empty[0]), 32'd0);

        // Drain-mode flush with a partial word
        do_reset();
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'h6, 1'b0, 1'b0);
        cyc(1'b1, 4'h8, 1'b0, 1'b0);
        chk("t2_partial", 32'(partial[0]), 32'd3);
        chk("t2_ready_pre", 32'(wr_ready[0]), 32'd1);
        #1;
        wr_valid = 1'b0;
        flush = 1'b1;
        #1 chk("t2_ready_comb", 32'(wr_ready[0]), 32'd0);
        @(negedge clk);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t2_pad_word", rd_data[0], 32'h0000086A);
        chk("t2_pad_level", 32'(level[0]), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t2_wait_done", 32'(flush_done[0]), 32'd0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        chk("t2_pop_level", 32'(level[0]), 32'd0);
        chk("t2_pop_done", 32'(flush_done[0]), 32'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t2_done", 32'(flush_done[0]), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t2_idle_done", 32'(flush_done[0]), 32'd0);
        chk("t2_idle_ready", 32'(wr_ready[0]), 32'd1);

        // Full storage with 7 held lanes blocks the 8th lane
        do_reset();
        for (int i = 0; i < 39; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        chk("t3_full", 32'(full[0]), 32'd1);
        chk("t3_partial", 32'(partial[0]), 32'd7);
        chk("t3_ready", 32'(wr_ready[0]), 32'd0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("t3_drop", 32'(partial[0]), 32'd7);
        cyc(1'b1, 4'hF, 1'b1, 1'b0);
        chk("t3_pop_level", 32'(level[0]), 32'd3);
        chk("t3_pop_ready", 32'(wr_ready[0]), 32'd1);
        chk("t3_head", rd_data[0], 32'hFEDCBA98);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("t3_refull", 32'(full[0]), 32'd1);
        chk("t3_partial0", 32'(partial[0]), 32'd0);

        // Discard-mode flush
        do_reset();
        for (int i = 0; i < 19; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        chk("t4_level", 32'(level[1]), 32'd2);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t4_pad_level", 32'(level[1]), 32'd3);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t4_clr_level", 32'(level[1]), 32'd0);
        chk("t4_clr_empty", 32'(empty[1]), 32'd1);
        chk("t4_done", 32'(flush_done[1]), 32'd1);
        chk("t4_rd_data", rd_data[1], 32'h0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t4_idle_done", 32'(flush_done[1]), 32'd0);

        // Asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t5_drain_level", 32'(level[0]), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("t5_level", 32'(level[0]), 32'd0);
        chk("t5_avail", 32'(data_avail[0]), 32'd0);
        chk("t5_empty", 32'(empty[0]), 32'd1);
        chk("t5_rd_data", rd_data[0], 32'h0);
        chk("t5_ready_fl", 32'(wr_ready[0]), 32'd0);
        flush = 1'b0;
        #1 chk("t5_ready", 32'(wr_ready[0]), 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_post_ready", 32'(wr_ready[0]), 32'd1);
        chk("t5_post_done", 32'(flush_done[0]), 32'd0);

        // Simultaneous push and pop, then pop at empty
        do_reset();
        for (int i = 0; i < 23; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b1, 1'b0);
        chk("t6_level", 32'(level[0]), 32'd2);
        chk("t6_head", rd_data[0], 32'hFEDCBA98);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t6_head2", rd_data[0], 32'h96543210);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t6_empty_level", 32'(level[0]), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(8 - i), 1'b0, 1'b0);
        chk("t6_new_head", rd_data[0], 32'h12345678);
        chk("t6_new_level", 32'(level[0]), 32'd1);

        // Randomised traffic with flushes and occasional mid-cycle resets
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            wv = ($urandom_range(0, 9) < 7);
            rv = ($urandom_range(0, 9) < 4);
            wd = 4'($urandom_range(0, 15));
            if (fl_hold > 0) fl_hold--;
            else if ($urandom_range(0, 29) == 0) fl_hold = $urandom_range(1, 12);
            fl = (fl_hold > 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
            cyc(wv, wd, rv, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
